// File: rtl/wptr_full_pkg.sv
// Shared async-FIFO helpers: pointer width convention and Gray conversions.
// Used by both the write-side (full) and read-side (empty) pointer blocks.
package wptr_full_pkg;

  // Pointers carry one extra wrap bit beyond the address.
  function automatic int ptr_w(input int asize);
    return asize + 1;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/wptr_full_if.sv
// Write-side pointer bundle between the FIFO writer and the write pointer block.
// master: writer / FIFO top drives requests; slave: wptr_full drives status.
interface wptr_full_if #(
  parameter int ASIZE = 4
);
  import wptr_full_pkg::*;

  localparam int PTR_W = ptr_w(ASIZE);

  logic             wr_inc;
  logic [PTR_W-1:0] r2w_ptr;
  logic             wr_ovf_clr;
  logic             wr_accept;
  logic [ASIZE-1:0] wr_addr;
  logic [PTR_W-1:0] wr_ptr;
  logic             wr_full;
  logic             wr_almost_full;
  logic [PTR_W-1:0] wr_level;
  logic             wr_ovf;

  modport master (
    output wr_inc, r2w_ptr, wr_ovf_clr,
    input  wr_accept, wr_addr, wr_ptr, wr_full,
    input  wr_almost_full, wr_level, wr_ovf
  );

  modport slave (
    input  wr_inc, r2w_ptr, wr_ovf_clr,
    output wr_accept, wr_addr, wr_ptr, wr_full,
    output wr_almost_full, wr_level, wr_ovf
  );

endinterface

// File: rtl/wptr_full_gray2bin.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down).
// Ports: gray in (W bits), bin out (W bits).
module wptr_full_gray2bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end

endmodule

// File: rtl/wptr_full.sv
// Write-domain pointer/flag block: binary+Gray write pointer, full, almost-full,
// fill level, sticky overflow. Ports: wr_clk, wr_rst, bus (wptr_full_if.slave).
module wptr_full
  import wptr_full_pkg::*;
#(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 4,
  parameter int AFULL_LVL = 12
) (
  input  logic        wr_clk,
  input  logic        wr_rst,
  wptr_full_if.slave  bus
);

  localparam int PTR_W = ptr_w(ASIZE);

  // DSIZE only sizes the RAM beside this block; nothing to build here.
  if (DSIZE < 1) begin : g_no_data
  end

  logic [PTR_W-1:0] wbin;
  logic [PTR_W-1:0] wbnext;
  logic [PTR_W-1:0] wgnext;
  logic [PTR_W-1:0] rbin_s;
  logic [PTR_W-1:0] rfull_g;
  logic [PTR_W-1:0] level_next;
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] level_q;
  logic             full_q;
  logic             afull_q;
  logic             ovf_q;
  logic             accept;

  wptr_full_gray2bin #(.W(PTR_W)) u_g2b (
    .gray (bus.r2w_ptr),
    .bin  (rbin_s)
  );

  // Reset also masks the RAM write enable.
  assign accept = bus.wr_inc & ~full_q & ~wr_rst;

  assign wbnext = wbin + PTR_W'(accept);
  assign wgnext = (wbnext >> 1) ^ wbnext;

  // Full when the writer is exactly one lap ahead: Gray form flips top two bits.
  assign rfull_g = {~bus.r2w_ptr[ASIZE:ASIZE-1],
                    bus.r2w_ptr[ASIZE-2:0]};

  assign level_next = wbnext - rbin_s;

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      wbin    <= '0;
      ptr_q   <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wbin    <= wbnext;
      ptr_q   <= wgnext;
      full_q  <= (wgnext == rfull_g);
      afull_q <= (level_next >= PTR_W'(AFULL_LVL));
      level_q <= level_next;
      if (bus.wr_inc & full_q)
        ovf_q <= 1'b1;
      else if (bus.wr_ovf_clr)
        ovf_q <= 1'b0;
    end
  end

  assign bus.wr_accept      = accept;
  assign bus.wr_addr        = wbin[ASIZE-1:0];
  assign bus.wr_ptr         = ptr_q;
  assign bus.wr_full        = full_q;
  assign bus.wr_almost_full = afull_q;
  assign bus.wr_level       = level_q;
  assign bus.wr_ovf         = ovf_q;

endmodule

// File: tb/tb_wptr_full.sv
// Randomised self-checking bench for wptr_full (ASIZE=4, AFULL_LVL=12).
// Counts-based reference model plus literal checks of key scenarios.
module tb_wptr_full;

  logic wr_clk = 1'b0;
  logic wr_rst;

  wptr_full_if #(.ASIZE(4)) bus ();

  wptr_full #(
    .DSIZE     (8),
    .ASIZE     (4),
    .AFULL_LVL (12)
  ) dut (
    .wr_clk (wr_clk),
    .wr_rst (wr_rst),
    .bus    (bus)
  );

  always #5 wr_clk = ~wr_clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int gray5(input int v);
    int b;
    b = v & 31;
    return b ^ (b >> 1);
  endfunction

  // Reader position as a plain count; the bus sees its Gray code.
  int rc = 0;
  assign bus.r2w_ptr = 5'(gray5(rc));

  // Model: total accepted writes vs reader count, everything else derived.
  int m_wc = 0;
  int m_level = 0;
  bit m_full = 0;
  bit m_af = 0;
  bit m_ovf = 0;
  int m_epoch = 0;
  int m_nw;
  int m_nlvl;

  always_comb begin
    m_nw = m_wc + ((bus.wr_inc && !m_full) ? 1 : 0);
    m_nlvl = (m_nw - rc) & 31;
  end

  always @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      m_wc    <= 0;
      m_level <= 0;
      m_full  <= 0;
      m_af    <= 0;
      m_ovf   <= 0;
      m_epoch <= m_epoch + 1;
    end else begin
      m_wc    <= m_nw;
      m_level <= m_nlvl;
      m_full  <= (m_nlvl == 16);
      m_af    <= (m_nlvl >= 12);
      if (bus.wr_inc && m_full) m_ovf <= 1;
      else if (bus.wr_ovf_clr) m_ovf <= 0;
    end
  end

  int prev_ptr = 0;
  int prev_epoch = -1;

  always @(negedge wr_clk) begin
    check("accept", int'(bus.wr_accept),
          (bus.wr_inc && !m_full && !wr_rst) ? 1 : 0);
    check("addr", int'(bus.wr_addr), m_wc & 15);
    check("ptr", int'(bus.wr_ptr), gray5(m_wc));
    check("full", int'(bus.wr_full), int'(m_full));
    check("afull", int'(bus.wr_almost_full), int'(m_af));
    check("level", int'(bus.wr_level), m_level);
    check("ovf", int'(bus.wr_ovf), int'(m_ovf));
    if (m_epoch == prev_epoch && int'(bus.wr_ptr) != prev_ptr)
      check("ptr_hamming", $countones(int'(bus.wr_ptr) ^ prev_ptr), 1);
    prev_ptr = int'(bus.wr_ptr);
    prev_epoch = m_epoch;
  end

  task automatic cyc();
    @(posedge wr_clk);
    #1;
  endtask

  int h1, h2, n;

  initial begin
    wr_rst = 1'b1;
    bus.wr_inc = 1'b1;
    bus.wr_ovf_clr = 1'b0;
    repeat (2) cyc();
    check("rst_ptr", int'(bus.wr_ptr), 0);
    check("rst_addr", int'(bus.wr_addr), 0);
    check("rst_full", int'(bus.wr_full), 0);
    check("rst_level", int'(bus.wr_level), 0);
    check("rst_accept", int'(bus.wr_accept), 0);

    // Fill with reader parked at 0.
    wr_rst = 1'b0;
    repeat (16) cyc();
    check("fill_full", int'(bus.wr_full), 1);
    check("fill_ptr", int'(bus.wr_ptr), 5'b11000);
    check("fill_level", int'(bus.wr_level), 16);
    check("fill_afull", int'(bus.wr_almost_full), 1);

    // Overflow attempts.
    repeat (3) cyc();
    check("ovf_accept", int'(bus.wr_accept), 0);
    check("ovf_ptr", int'(bus.wr_ptr), 5'b11000);
    check("ovf_set", int'(bus.wr_ovf), 1);
    bus.wr_ovf_clr = 1'b1;
    cyc();
    check("ovf_set_prio", int'(bus.wr_ovf), 1);
    bus.wr_inc = 1'b0;
    cyc();
    check("ovf_clr", int'(bus.wr_ovf), 0);
    bus.wr_ovf_clr = 1'b0;

    // Drain release by one read.
    rc = 1;
    cyc();
    check("drain_full", int'(bus.wr_full), 0);
    check("drain_level", int'(bus.wr_level), 15);
    bus.wr_inc = 1'b1;
    cyc();
    bus.wr_inc = 1'b0;
    check("refill_full", int'(bus.wr_full), 1);

    // Wrap: reader trails writer by two cycles.
    wr_rst = 1'b1;
    rc = 0;
    #2;
    wr_rst = 1'b0;
    h1 = 0;
    h2 = 0;
    n = 0;
    while (m_wc < 40 && n < 400) begin
      bus.wr_inc = ($urandom_range(0, 3) != 0);
      bus.wr_ovf_clr = ($urandom_range(0, 7) == 0);
      cyc();
      rc = h2;
      h2 = h1;
      h1 = m_wc;
      n++;
    end
    check("wrap_done", (m_wc >= 40) ? 1 : 0, 1);

    // Run up to level 9, then reset between edges.
    bus.wr_ovf_clr = 1'b0;
    n = 0;
    while (m_level != 9 && n < 40) begin
      bus.wr_inc = 1'b1;
      cyc();
      n++;
    end
    check("lvl9_reached", m_level, 9);
    wr_rst = 1'b1;
    #1;
    check("mid_ptr", int'(bus.wr_ptr), 0);
    check("mid_addr", int'(bus.wr_addr), 0);
    check("mid_full", int'(bus.wr_full), 0);
    check("mid_afull", int'(bus.wr_almost_full), 0);
    check("mid_level", int'(bus.wr_level), 0);
    check("mid_ovf", int'(bus.wr_ovf), 0);
    check("mid_accept", int'(bus.wr_accept), 0);
    rc = 0;
    #1;
    wr_rst = 1'b0;
    #1;
    check("resume_addr0", int'(bus.wr_addr), 0);
    check("resume_accept", int'(bus.wr_accept), 1);
    cyc();
    check("resume_addr1", int'(bus.wr_addr), 1);

    // Random traffic with a slower reader, hitting full and overflow.
    for (int i = 0; i < 400; i++) begin
      bus.wr_inc = ($urandom_range(0, 3) != 0);
      bus.wr_ovf_clr = ($urandom_range(0, 15) == 0);
      if (rc < m_wc && $urandom_range(0, 9) < 3) rc = rc + 1;
      cyc();
    end

    bus.wr_inc = 1'b0;
    repeat (2) cyc();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
